// File: rtl/seq_detector_param_if.sv
// Serial-stream bundle for seq_detector_param: data bit, valid strobe,
// pattern reload, and the match pulse and count coming back.
interface seq_detector_param_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             i;
    logic             i_valid;
    logic             cfg_load;
    logic [N-1:0]     cfg_pattern;
    logic             out;
    logic [CNT_W-1:0] match_count;

    modport master (output i, i_valid, cfg_load, cfg_pattern,
                    input  out, match_count);
    modport slave  (input  i, i_valid, cfg_load, cfg_pattern,
                    output out, match_count);
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time reload, registered
// one-cycle match pulse and a saturating match counter.
module seq_detector_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           OVERLAP = 1,
    parameter int           CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);
    localparam int               FW      = $clog2(N + 1);
    localparam logic [FW-1:0]    FULL    = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]     pat_reg;
    logic [N-1:0]     hist;
    logic [FW-1:0]    fill;
    logic             out_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N-1:0]     hist_n;
    logic [FW-1:0]    fill_n;
    logic             match;

    // fill tracks how many fresh bits are in hist, so a partial history
    // left over from reset or reload can never alias the pattern.
    always_comb begin
        hist_n = {hist[N-2:0], bus.i};
        fill_n = (fill == FULL) ? fill : fill + FW'(1);
        match  = (fill_n == FULL) && (hist_n == pat_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.cfg_load) begin
            pat_reg <= bus.cfg_pattern;
            hist    <= '0;
            fill    <= '0;
            out_q   <= 1'b0;
        end else if (bus.i_valid) begin
            out_q <= match;
            hist  <= hist_n;
            // Non-overlap mode restarts collection after a hit.
            fill  <= (match && OVERLAP == 0) ? '0 : fill_n;
            if (match && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            out_q <= 1'b0;
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Drives three detector configurations (overlap, non-overlap, 2-bit counter)
// with shared directed and random stimulus against a queue-based model.
module tb_seq_detector_param;
    localparam int N = 4;
    localparam logic [N-1:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst, i, i_valid, cfg_load;
    logic [N-1:0] cfg_pattern;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.N(N), .CNT_W(8)) ifa ();
    seq_detector_param_if #(.N(N), .CNT_W(8)) ifb ();
    seq_detector_param_if #(.N(N), .CNT_W(2)) ifc ();

    assign ifa.i = i; assign ifa.i_valid = i_valid;
    assign ifa.cfg_load = cfg_load; assign ifa.cfg_pattern = cfg_pattern;
    assign ifb.i = i; assign ifb.i_valid = i_valid;
    assign ifb.cfg_load = cfg_load; assign ifb.cfg_pattern = cfg_pattern;
    assign ifc.i = i; assign ifc.i_valid = i_valid;
    assign ifc.cfg_load = cfg_load; assign ifc.cfg_pattern = cfg_pattern;

    seq_detector_param #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    seq_detector_param #(.N(N), .PATTERN(PAT), .OVERLAP(0), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    seq_detector_param #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    // Reference model: history as a queue of the last accepted bits.
    bit           hq [3][$];
    logic [N-1:0] mpat [3];
    logic         mout [3];
    int           mcnt [3];
    int           ovl  [3] = '{1, 0, 1};
    int           cmax [3] = '{255, 255, 3};
    int           pulses_c;

    task automatic model(input logic r, input logic ld, input logic [N-1:0] p,
                         input logic v, input logic b);
        for (int m = 0; m < 3; m++) begin
            if (r) begin
                mpat[m] = PAT; hq[m].delete(); mout[m] = 0; mcnt[m] = 0;
            end else if (ld) begin
                mpat[m] = p; hq[m].delete(); mout[m] = 0;
            end else if (v) begin
                logic [N-1:0] w;
                hq[m].push_back(b);
                if (hq[m].size() > N) void'(hq[m].pop_front());
                w = '0;
                foreach (hq[m][k]) w = {w[N-2:0], hq[m][k]};
                mout[m] = (hq[m].size() == N) && (w == mpat[m]);
                if (mout[m]) begin
                    if (mcnt[m] < cmax[m]) mcnt[m]++;
                    if (ovl[m] == 0) hq[m].delete();
                end
            end else begin
                mout[m] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [N-1:0] p,
                        input logic v, input logic b);
        rst = r; cfg_load = ld; cfg_pattern = p; i_valid = v; i = b;
        model(r, ld, p, v, b);
        @(posedge clk); #1;
        chk("a_out", int'(ifa.out), int'(mout[0]));
        chk("a_cnt", int'(ifa.match_count), mcnt[0]);
        chk("b_out", int'(ifb.out), int'(mout[1]));
        chk("b_cnt", int'(ifb.match_count), mcnt[1]);
        chk("c_out", int'(ifc.out), int'(mout[2]));
        chk("c_cnt", int'(ifc.match_count), mcnt[2]);
        if (ifc.out === 1'b1) pulses_c++;
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) step(0, 0, '0, 1, v[k]);
    endtask

    initial begin
        int sa, sb, ac;
        logic [N-1:0] rp;
        pulses_c = 0;
        rst = 1; cfg_load = 0; cfg_pattern = '0; i_valid = 0; i = 0;
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        chk("rst_a_out", int'(ifa.out), 0);
        chk("rst_a_cnt", int'(ifa.match_count), 0);

        // Overlap on/off over 1,0,1,1,0,1,1
        bits(16'b1011011, 7);
        chk("ovl_on_cnt", int'(ifa.match_count), 2);
        chk("ovl_off_cnt", int'(ifb.match_count), 1);

        // Valid gap does not break a sequence
        step(1, 0, '0, 0, 0);
        bits(16'b10, 2);
        repeat (3) step(0, 0, '0, 0, 0);
        bits(16'b11, 2);
        chk("gap_pulse", int'(ifa.out), 1);

        // Reset mid-sequence discards history
        step(1, 0, '0, 0, 0);
        bits(16'b101, 3);
        step(1, 0, '0, 0, 0);
        bits(16'b1, 1);
        chk("rst_mid_nopulse", int'(ifa.out), 0);
        bits(16'b1011, 4);
        chk("rst_mid_pulse", int'(ifa.out), 1);

        // Reload to 0000 mid-sequence
        bits(16'b101, 3);
        sa = int'(ifa.match_count);
        step(0, 1, 4'b0000, 1, 1);
        chk("load_keeps_cnt", int'(ifa.match_count), sa);
        bits(16'b000, 3);
        chk("load_partial", int'(ifa.out), 0);
        bits(16'b0, 1);
        chk("load_4th_zero", int'(ifa.out), 1);
        bits(16'b0, 1);
        chk("zeros_every_cycle", int'(ifa.out), 1);
        chk("zeros_nonovl", int'(ifb.out), 0);

        // Load colliding with completing bit
        step(0, 1, PAT, 0, 0);
        bits(16'b101, 3);
        sa = int'(ifa.match_count); sb = int'(ifb.match_count);
        step(0, 1, PAT, 1, 1);
        chk("coll_out", int'(ifa.out), 0);
        chk("coll_cnt_a", int'(ifa.match_count), sa);
        chk("coll_cnt_b", int'(ifb.match_count), sb);

        // Saturation of the 2-bit counter
        step(1, 0, '0, 0, 0);
        pulses_c = 0;
        repeat (5) bits(16'b1011, 4);
        chk("sat_cnt", int'(ifc.match_count), 3);
        chk("sat_pulses", pulses_c, 5);

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            ac = $urandom_range(0, 99);
            rp = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            step(ac < 2, (ac >= 2 && ac < 5), rp,
                 $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
